// File: rtl/demux5_8b_queue.sv
// 1-to-5 byte distributor: one producer beat per cycle, one FIFO per sink.
// Optional invalid-select drop counter when DEMUX5_DROP_CNT_EN is defined.
module demux5_8b_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int NDEST = 5
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [2:0]             in_sel,
  output logic [NDEST-1:0]       out_valid,
  input  logic [NDEST-1:0]       out_ready,
  output logic [NDEST*WIDTH-1:0] out_data,
  output logic                   busy
`ifdef DEMUX5_DROP_CNT_EN
  ,
  output logic [7:0]             drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PONE = 1;
  localparam logic [CW-1:0] CONE = 1;
  localparam logic [CW-1:0] CFULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem  [NDEST][DEPTH];
  logic [AW-1:0]    r_wptr [NDEST];
  logic [AW-1:0]    r_rptr [NDEST];
  logic [CW-1:0]    r_cnt  [NDEST];

  logic [NDEST-1:0] w_full;
  logic [NDEST-1:0] w_valid;
  logic [NDEST-1:0] w_push;
  logic [NDEST-1:0] w_pop;
  logic             w_sel_ok;
  logic             w_accept;

  always_comb begin
    w_full  = '0;
    w_valid = '0;
    for (int i = 0; i < NDEST; i++) begin
      w_full[i]  = (r_cnt[i] == CFULL);
      w_valid[i] = (r_cnt[i] != '0);
    end
  end

  assign w_sel_ok = (in_sel < 3'd5);

  // Invalid selects are always taken so a bad beat never stalls the producer.
  always_comb begin
    in_ready = 1'b1;
    if (w_sel_ok)
      in_ready = ~w_full[in_sel];
  end

  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int i = 0; i < NDEST; i++) begin
      w_push[i] = w_accept & (in_sel == 3'(i));
      w_pop[i]  = w_valid[i] & out_ready[i];
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NDEST; i++)
      if (w_valid[i])
        out_data[i*WIDTH +: WIDTH] = r_mem[i][r_rptr[i]];
  end

  assign out_valid = w_valid;
  assign busy      = |w_valid;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NDEST; i++)
      if (w_push[i])
        r_mem[i][r_wptr[i]] <= in_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NDEST; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NDEST; i++) begin
        if (w_push[i])
          r_wptr[i] <= r_wptr[i] + PONE;
        if (w_pop[i])
          r_rptr[i] <= r_rptr[i] + PONE;
        unique case (1'b1)
          (w_push[i] & ~w_pop[i]): r_cnt[i] <= r_cnt[i] + CONE;
          (~w_push[i] & w_pop[i]): r_cnt[i] <= r_cnt[i] - CONE;
          default:                 r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

`ifdef DEMUX5_DROP_CNT_EN
  logic [7:0] r_drop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_drop <= '0;
    else if (w_accept & ~w_sel_ok & (r_drop != 8'hFF))
      r_drop <= r_drop + 8'd1;
  end

  assign drop_cnt = r_drop;
`endif

endmodule
